control_fsm: RTL and testbench
==============================

# control_fsm

Sequencer for the 16-bit RISC datapath. It steps each instruction through fetch, decode and execute. It drives every datapath, program-counter, instruction-register and RAM control strobe from `opcode`/`op`, which the decoder extracts from the instruction register. It sits between the instruction decoder and the datapath/counter/RAM in the CPU top level.

## Interface
Parameters:
- none; encodings are fixed in the package.

Ports:
- `clk` in 1: system clock, all state changes on rising edge.
- `reset` in 1: synchronous, active-high; one clock, synchronous reset, active-high.
- `opcode` in 3: instruction opcode from decoder (110 MOV, 101 ALU, 011 LDR, 100 STR, 111 HALT).
- `op` in 2: sub-operation from decoder.
- `nsel` out 2: register select (00 Rn, 01 Rd, 10 Rm).
- `vsel` out 2: writeback source (00 mdata, 01 sximm8, 10 {0,PC}, 11 C).
- `loada`, `loadb`, `asel`, `bsel`, `loadc`, `loads`, `write` out 1 each: datapath strobes. `bsel`=1 selects sximm5; `asel`=1 selects zero.
- `loadpc` out 1: increment PC.
- `loadir` out 1: capture RAM dout into instruction register.
- `msel` out 1: RAM address source (0 PC, 1 data-address register).
- `loadaddr` out 1: load data-address register from C.
- `mwrite` out 1: RAM write enable.
- `halted` out 1: high while in HALT.

## Operation
- Moore machine. All outputs are a pure function of the registered state. Any output not listed for a state is 0.
- Fetch: S_RST → IF1 (`msel`=0) → IF2 (`msel`=0, `loadir`) → UPD_PC (`loadpc`) → DECODE (no strobes).
- DECODE branches on {`opcode`,`op`}:
  - MOV imm (110/10): WR_IMM (`nsel`=Rn, `vsel`=01, `write`) → IF1.
  - MOV reg (110/00) and MVN (101/11): GET_B (`nsel`=Rm, `loadb`) → ALU (`asel`=1 for MOV, 0 for MVN; `bsel`=0; `loadc`) → WR_RD (`nsel`=Rd, `vsel`=11, `write`) → IF1.
  - ADD/AND (101/00, 101/10): GET_A (`nsel`=Rn, `loada`) → GET_B → ALU (`asel`=0, `bsel`=0, `loadc`) → WR_RD → IF1.
  - CMP (101/01): GET_A → GET_B → STATUS (`asel`=0, `bsel`=0, `loads`) → IF1. No `write`, no `loadc`.
  - LDR (011/00): GET_A → ADDR (`asel`=0, `bsel`=1, `loadc`) → LD_ADDR (`loadaddr`) → MEM_RD (`msel`=1) → MEM_WB (`msel`=1, `nsel`=Rd, `vsel`=00, `write`) → IF1.
  - STR (100/00): GET_A → ADDR → LD_ADDR → GET_RD (`nsel`=Rd, `loadb`) → STR_C (`asel`=1, `bsel`=0, `loadc`) → MEM_WR (`msel`=1, `mwrite`) → IF1.
  - HALT (111/xx): see Configuration.
  - Any other combination (including x/z inputs): NOP → IF1.
- `opcode`/`op` are sampled only in DECODE. Later states hold their own path identity in the state encoding and do not re-read the inputs.
- `write`, `mwrite` and `loadir` are each asserted for exactly one cycle per instruction.

## Timing
- Reset: while `reset` is high at an edge, the next state is S_RST. In S_RST every output is 0, including `halted`. One cycle after `reset` deasserts, the FSM is in IF1.
- Reset mid-instruction: on the edge that samples `reset`=1, the state goes to S_RST. No strobe may be asserted in the following cycle, so a pending `write`/`mwrite` is lost.
- Cycle counts from IF1 to the next IF1: MOV imm 5, MOV reg/MVN/CMP 7, ADD/AND 8, LDR 9, STR 10, NOP 5.
- RAM read is synchronous. The address is presented in IF1 (or MEM_RD) and the data is valid in IF2 (or MEM_WB).

## Configuration
- `CTRL_HALT_EN` defined: opcode 111 goes DECODE → HALT. HALT asserts `halted`=1 with every other output 0, and stays there until `reset`.
- `CTRL_HALT_EN` undefined: opcode 111 follows the NOP path; `halted` is tied to 0.

## Structure
- `cpu_ctrl_pkg` holds:
  - state enum (5-bit);
  - opcode constants MOV/ALU/STR/LDR/HALT;
  - op constants ADD/CMP/AND/MVN;
  - nsel codes RN/RD/RM;
  - vsel codes MDATA/SXIMM8/PC/C.
- One sub-module, `ctrl_outputs`: purely combinational state → control-word decode. `control_fsm` keeps the state register and next-state logic.

## Test plan
- Reset, then MOV R0,#5 (110/10): `loadir` in cycle 2 after IF1 entry, `loadpc` in cycle 3. In cycle 5, `nsel`=00, `vsel`=01, `write`=1. Back in IF1 at cycle 6.
- ADD (101/00): `loada` then `loadb` in consecutive cycles, then `loadc` with `asel`=`bsel`=0, then `write` with `vsel`=11, `nsel`=01. 8-cycle period.
- CMP (101/01): `loads`=1 exactly once; `write` and `loadc` never asserted. Next IF1 7 cycles later.
- LDR then STR: LDR shows `bsel`=1/`loadc`, then `loadaddr`, then `msel`=1 for 2 cycles with `write`/`vsel`=00 in the second. STR shows `mwrite`=1 for exactly one cycle with `msel`=1.
- `reset` pulsed during STR GET_RD: the next cycle is S_RST with all outputs 0, and `mwrite` is never seen. IF1 follows after deassert.
- Opcode 111: with `CTRL_HALT_EN`, `halted`=1 held for 20 cycles with no strobes, and reset clears it. Without the macro, the FSM returns to IF1 after 5 cycles.

Source files
------------

// File: rtl/control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg -- shared encodings for the RISC control sequencer.
//
// Holds the 5-bit sequencer state enum, the opcode/op constants produced by the
// instruction decoder, the nsel/vsel mux codes and the packed control word that
// ctrl_outputs produces and control_fsm fans out onto its interface.
//
// Optional feature: CTRL_HALT_EN (see control_fsm.sv / control_fsm_outputs.sv).
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  // Execute-phase states carry their instruction path in the encoding, so the
  // FSM never has to look at opcode/op again after DECODE.
  typedef enum logic [4:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPD_PC,
    S_DECODE,
    S_WR_IMM,
    S_GET_A_ALU,
    S_GET_A_CMP,
    S_GET_A_LDR,
    S_GET_A_STR,
    S_GET_B_MOV,
    S_GET_B_ALU,
    S_GET_B_CMP,
    S_ALU_MOV,
    S_ALU_OP,
    S_WR_RD,
    S_STATUS,
    S_ADDR_LDR,
    S_ADDR_STR,
    S_LDADDR_LDR,
    S_LDADDR_STR,
    S_MEM_RD,
    S_MEM_WB,
    S_GET_RD,
    S_STR_C,
    S_MEM_WR,
    S_NOP,
    S_HALT
  } state_t;

  // Opcodes
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // Sub-operations
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MEM     = 2'b00;

  // Register-file read/write select
  localparam logic [1:0] NSEL_RN = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RM = 2'b10;

  // Writeback source
  localparam logic [1:0] VSEL_MDATA  = 2'b00;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
  localparam logic [1:0] VSEL_PC     = 2'b10;
  localparam logic [1:0] VSEL_C      = 2'b11;

  typedef struct packed {
    logic       halted;
    logic       mwrite;
    logic       loadaddr;
    logic       msel;
    logic       loadir;
    logic       loadpc;
    logic       write;
    logic       loads;
    logic       loadc;
    logic       bsel;
    logic       asel;
    logic       loadb;
    logic       loada;
    logic [1:0] vsel;
    logic [1:0] nsel;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_IDLE = '0;

endpackage

// File: rtl/control_fsm_if.sv
// -----------------------------------------------------------------------------
// control_fsm_if -- decoder inputs and control strobes of the sequencer.
//
// master : the sequencer (reads opcode/op, drives every strobe)
// slave  : the datapath / PC / IR / RAM side (drives opcode/op, reads strobes)
//
// opcode[2:0], op[1:0]         : from the instruction decoder
// nsel[1:0], vsel[1:0]         : register select / writeback source
// loada..write                 : datapath strobes
// loadpc, loadir               : PC increment / instruction register capture
// msel, loadaddr, mwrite       : RAM address select, address reg load, write
// halted                       : high while halted
// -----------------------------------------------------------------------------
interface control_fsm_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [1:0] nsel;
  logic [1:0] vsel;
  logic       loada;
  logic       loadb;
  logic       asel;
  logic       bsel;
  logic       loadc;
  logic       loads;
  logic       write;
  logic       loadpc;
  logic       loadir;
  logic       msel;
  logic       loadaddr;
  logic       mwrite;
  logic       halted;

  modport master (
    input  opcode, op,
    output nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write,
           loadpc, loadir, msel, loadaddr, mwrite, halted
  );

  modport slave (
    output opcode, op,
    input  nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write,
           loadpc, loadir, msel, loadaddr, mwrite, halted
  );
endinterface

// File: rtl/control_fsm_outputs.sv
// -----------------------------------------------------------------------------
// ctrl_outputs -- Moore output decode of the control sequencer.
//
// Purely combinational: every control strobe is a function of the registered
// state only. Any field not set for a state stays 0.
//
// state : current sequencer state
// ctrl  : packed control word (see cpu_ctrl_pkg::ctrl_word_t)
//
// CTRL_HALT_EN defined : S_HALT raises 'halted'.
// CTRL_HALT_EN undefined: 'halted' is constant 0.
// -----------------------------------------------------------------------------
module ctrl_outputs
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t ctrl
);

  always_comb begin
    // NOTE: default everything first so no path through the case leaves a
    // field unassigned (which would infer a latch).
    ctrl = CTRL_IDLE;
    unique case (state)
      S_IF2:    ctrl.loadir = 1'b1;
      S_UPD_PC: ctrl.loadpc = 1'b1;
      S_WR_IMM: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.vsel  = VSEL_SXIMM8;
        ctrl.write = 1'b1;
      end
      S_GET_A_ALU, S_GET_A_CMP, S_GET_A_LDR, S_GET_A_STR: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.loada = 1'b1;
      end
      S_GET_B_MOV, S_GET_B_ALU, S_GET_B_CMP: begin
        ctrl.nsel  = NSEL_RM;
        ctrl.loadb = 1'b1;
      end
      // asel=1 feeds zero into the ALU's A input so C = 0 + B (plain move).
      S_ALU_MOV: begin
        ctrl.asel  = 1'b1;
        ctrl.loadc = 1'b1;
      end
      S_ALU_OP:  ctrl.loadc = 1'b1;
      S_WR_RD: begin
        ctrl.nsel  = NSEL_RD;
        ctrl.vsel  = VSEL_C;
        ctrl.write = 1'b1;
      end
      S_STATUS:  ctrl.loads = 1'b1;
      S_ADDR_LDR, S_ADDR_STR: begin
        ctrl.bsel  = 1'b1;
        ctrl.loadc = 1'b1;
      end
      S_LDADDR_LDR, S_LDADDR_STR: ctrl.loadaddr = 1'b1;
      // The RAM read is synchronous: address in MEM_RD, data valid in MEM_WB,
      // so msel must stay on across both.
      S_MEM_RD:  ctrl.msel = 1'b1;
      S_MEM_WB: begin
        ctrl.msel  = 1'b1;
        ctrl.nsel  = NSEL_RD;
        ctrl.vsel  = VSEL_MDATA;
        ctrl.write = 1'b1;
      end
      S_GET_RD: begin
        ctrl.nsel  = NSEL_RD;
        ctrl.loadb = 1'b1;
      end
      S_STR_C: begin
        ctrl.asel  = 1'b1;
        ctrl.loadc = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.msel   = 1'b1;
        ctrl.mwrite = 1'b1;
      end
`ifdef CTRL_HALT_EN
      S_HALT:    ctrl.halted = 1'b1;
`endif
      default:   ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm -- fetch/decode/execute sequencer for the 16-bit RISC datapath.
//
// clk    : system clock, rising edge
// reset  : synchronous, active-high; forces S_RST (all outputs 0)
// bus    : control_fsm_if.master -- opcode/op in, all control strobes out
//
// Moore machine in three processes: state register and next-state logic here,
// output decode in ctrl_outputs. opcode/op are looked at only in DECODE.
//
// CTRL_HALT_EN defined : opcode 111 enters HALT and stays there until reset.
// CTRL_HALT_EN undefined: opcode 111 takes the NOP path.
// -----------------------------------------------------------------------------
module control_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  control_fsm_if.master  bus
);

  state_t     state;
  state_t     next_state;
  ctrl_word_t ctrl;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (reset) state <= S_RST;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_RST:    next_state = S_IF1;
      S_IF1:    next_state = S_IF2;
      S_IF2:    next_state = S_UPD_PC;
      S_UPD_PC: next_state = S_DECODE;

      // The only place the decoder fields are consulted. An x/z opcode fails
      // the HALT compare and falls through to the NOP default.
      S_DECODE: begin
        if (bus.opcode == OPC_HALT) begin
`ifdef CTRL_HALT_EN
          next_state = S_HALT;
`else
          next_state = S_NOP;
`endif
        end else begin
          case ({bus.opcode, bus.op})
            {OPC_MOV, OP_MOV_IMM}:                  next_state = S_WR_IMM;
            {OPC_MOV, OP_MOV_REG}:                  next_state = S_GET_B_MOV;
            {OPC_ALU, OP_ADD}, {OPC_ALU, OP_AND}:   next_state = S_GET_A_ALU;
            {OPC_ALU, OP_MVN}:                      next_state = S_GET_B_ALU;
            {OPC_ALU, OP_CMP}:                      next_state = S_GET_A_CMP;
            {OPC_LDR, OP_MEM}:                      next_state = S_GET_A_LDR;
            {OPC_STR, OP_MEM}:                      next_state = S_GET_A_STR;
            default:                                next_state = S_NOP;
          endcase
        end
      end

      S_GET_A_ALU:  next_state = S_GET_B_ALU;
      S_GET_A_CMP:  next_state = S_GET_B_CMP;
      S_GET_A_LDR:  next_state = S_ADDR_LDR;
      S_GET_A_STR:  next_state = S_ADDR_STR;
      S_GET_B_MOV:  next_state = S_ALU_MOV;
      S_GET_B_ALU:  next_state = S_ALU_OP;
      S_GET_B_CMP:  next_state = S_STATUS;
      S_ALU_MOV,
      S_ALU_OP:     next_state = S_WR_RD;
      S_ADDR_LDR:   next_state = S_LDADDR_LDR;
      S_ADDR_STR:   next_state = S_LDADDR_STR;
      S_LDADDR_LDR: next_state = S_MEM_RD;
      S_LDADDR_STR: next_state = S_GET_RD;
      S_MEM_RD:     next_state = S_MEM_WB;
      S_GET_RD:     next_state = S_STR_C;
      S_STR_C:      next_state = S_MEM_WR;
      S_WR_IMM, S_WR_RD, S_STATUS,
      S_MEM_WB, S_MEM_WR, S_NOP:
                    next_state = S_IF1;
      S_HALT:       next_state = S_HALT;
      default:      next_state = S_RST;
    endcase
  end

  ctrl_outputs u_outputs (
    .state (state),
    .ctrl  (ctrl)
  );

  assign bus.nsel     = ctrl.nsel;
  assign bus.vsel     = ctrl.vsel;
  assign bus.loada    = ctrl.loada;
  assign bus.loadb    = ctrl.loadb;
  assign bus.asel     = ctrl.asel;
  assign bus.bsel     = ctrl.bsel;
  assign bus.loadc    = ctrl.loadc;
  assign bus.loads    = ctrl.loads;
  assign bus.write    = ctrl.write;
  assign bus.loadpc   = ctrl.loadpc;
  assign bus.loadir   = ctrl.loadir;
  assign bus.msel     = ctrl.msel;
  assign bus.loadaddr = ctrl.loadaddr;
  assign bus.mwrite   = ctrl.mwrite;
  assign bus.halted   = ctrl.halted;

endmodule

// File: tb/tb_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_control_fsm -- self-checking bench for control_fsm.
//
// The reference model is a per-instruction micro-operation table: for each
// instruction class it lists the control word expected on every cycle from IF1
// up to (not including) the next IF1. Outputs are sampled 1 ns after each
// rising edge. Build with +define+CTRL_HALT_EN to exercise the HALT feature.
// -----------------------------------------------------------------------------
module tb_control_fsm;

  logic clk = 1'b0;
  logic reset;

  control_fsm_if bus ();

  control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef CTRL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  // Observed word layout:
  // [16]halted [15]mwrite [14]loadaddr [13]msel [12]loadir [11]loadpc
  // [10]write [9]loads [8]loadc [7]bsel [6]asel [5]loadb [4]loada
  // [3:2]vsel [1:0]nsel
  typedef logic [16:0] word_t;

  localparam word_t W0       = 17'h0;
  localparam word_t N_RN     = 17'h0;
  localparam word_t N_RD     = 17'h1;
  localparam word_t N_RM     = 17'h2;
  localparam word_t V_MDATA  = 17'h0;
  localparam word_t V_SX     = 17'h4;
  localparam word_t V_C      = 17'hC;
  localparam word_t LOADA    = 17'h1 << 4;
  localparam word_t LOADB    = 17'h1 << 5;
  localparam word_t ASEL     = 17'h1 << 6;
  localparam word_t BSEL     = 17'h1 << 7;
  localparam word_t LOADC    = 17'h1 << 8;
  localparam word_t LOADS    = 17'h1 << 9;
  localparam word_t WRITE    = 17'h1 << 10;
  localparam word_t LOADPC   = 17'h1 << 11;
  localparam word_t LOADIR   = 17'h1 << 12;
  localparam word_t MSEL     = 17'h1 << 13;
  localparam word_t LOADADDR = 17'h1 << 14;
  localparam word_t MWRITE   = 17'h1 << 15;
  localparam word_t HALTED   = 17'h1 << 16;

  int tests = 0;
  int fails = 0;

  function automatic word_t observe();
    return {bus.halted, bus.mwrite, bus.loadaddr, bus.msel, bus.loadir,
            bus.loadpc, bus.write, bus.loads, bus.loadc, bus.bsel, bus.asel,
            bus.loadb, bus.loada, bus.vsel, bus.nsel};
  endfunction

  task automatic check(input string tag, input word_t expv);
    word_t o;
    o = observe();
    tests++;
    assert (o === expv) else begin
      fails++;
      $error("FAIL %s: observed %05h expected %05h", tag, o, expv);
    end
  endtask

  // Expected control words per cycle, IF1 onwards, for one instruction.
  function automatic void model(input logic [2:0] opc, input logic [1:0] op,
                                output word_t seq[$]);
    seq = '{W0, LOADIR, LOADPC, W0};  // IF1, IF2, PC update, decode
    if (opc == 3'b110 && op == 2'b10) begin          // MOV Rn,#imm
      seq.push_back(N_RN | V_SX | WRITE);
    end else if (opc == 3'b110 && op == 2'b00) begin // MOV Rd,Rm
      seq.push_back(N_RM | LOADB);
      seq.push_back(ASEL | LOADC);
      seq.push_back(N_RD | V_C | WRITE);
    end else if (opc == 3'b101 && (op == 2'b00 || op == 2'b10)) begin // ADD/AND
      seq.push_back(N_RN | LOADA);
      seq.push_back(N_RM | LOADB);
      seq.push_back(LOADC);
      seq.push_back(N_RD | V_C | WRITE);
    end else if (opc == 3'b101 && op == 2'b01) begin // CMP
      seq.push_back(N_RN | LOADA);
      seq.push_back(N_RM | LOADB);
      seq.push_back(LOADS);
    end else if (opc == 3'b101 && op == 2'b11) begin // MVN
      seq.push_back(N_RM | LOADB);
      seq.push_back(LOADC);
      seq.push_back(N_RD | V_C | WRITE);
    end else if (opc == 3'b011 && op == 2'b00) begin // LDR
      seq.push_back(N_RN | LOADA);
      seq.push_back(BSEL | LOADC);
      seq.push_back(LOADADDR);
      seq.push_back(MSEL);
      seq.push_back(MSEL | N_RD | V_MDATA | WRITE);
    end else if (opc == 3'b100 && op == 2'b00) begin // STR
      seq.push_back(N_RN | LOADA);
      seq.push_back(BSEL | LOADC);
      seq.push_back(LOADADDR);
      seq.push_back(N_RD | LOADB);
      seq.push_back(ASEL | LOADC);
      seq.push_back(MSEL | MWRITE);
    end else if (opc == 3'b111 && HALT_EN) begin     // HALT: watch 20 cycles
      for (int k = 0; k < 20; k++) seq.push_back(HALTED);
    end else begin                                   // NOP
      seq.push_back(W0);
    end
  endfunction

  // Runs one instruction starting in IF1. If rst_at >= 0, reset is raised
  // after checking that cycle and the task returns one edge later.
  task automatic run_instr(input string name, input logic [2:0] opc,
                           input logic [1:0] op, input int rst_at);
    word_t seq[$];
    model(opc, op, seq);
    bus.opcode = opc;
    bus.op     = op;
    for (int i = 0; i < seq.size(); i++) begin
      check($sformatf("%s c%0d", name, i), seq[i]);
      if (i == rst_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        return;
      end
      // Past DECODE the decoder fields must be ignored: scramble them.
      if (i >= 4) begin
        bus.opcode = 3'($urandom);
        bus.op     = 2'($urandom);
      end
      @(posedge clk); #1;
    end
  endtask

  logic [4:0] valid_codes [8] = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01,
                                  5'b101_10, 5'b101_11, 5'b011_00, 5'b100_00};

  initial begin
    logic [4:0] code;

    reset      = 1'b1;
    bus.opcode = 3'b000;
    bus.op     = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset state", W0);
    reset = 1'b0;
    @(posedge clk); #1;  // IF1

    // Directed instruction sequence
    run_instr("MOV imm", 3'b110, 2'b10, -1);
    run_instr("ADD",     3'b101, 2'b00, -1);
    run_instr("CMP",     3'b101, 2'b01, -1);
    run_instr("LDR",     3'b011, 2'b00, -1);
    run_instr("STR",     3'b100, 2'b00, -1);
    run_instr("MOV reg", 3'b110, 2'b00, -1);
    run_instr("MVN",     3'b101, 2'b11, -1);
    run_instr("AND",     3'b101, 2'b10, -1);
    run_instr("NOP 000", 3'b000, 2'b00, -1);
    run_instr("NOP 011/01", 3'b011, 2'b01, -1);

    // Reset during STR GET_RD (cycle 7 from IF1): pending mwrite is lost.
    run_instr("STR rst", 3'b100, 2'b00, 7);
    check("STR rst S_RST", W0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("STR rst IF1", W0);
    run_instr("post-rst LDR", 3'b011, 2'b00, -1);

    // Opcode 111: HALT when enabled, NOP otherwise.
    if (HALT_EN) begin
      run_instr("HALT", 3'b111, 2'(2'($urandom)), 23);
      check("HALT cleared", W0);
      reset = 1'b0;
      @(posedge clk); #1;
    end else begin
      run_instr("111 as NOP", 3'b111, 2'b01, -1);
    end

    // Randomized instruction stream (no HALT so the stream keeps going).
    repeat (40) begin
      if ($urandom_range(0, 9) < 8) begin
        code = valid_codes[$urandom_range(0, 7)];
      end else begin
        code = 5'($urandom);
        if (code[4:2] == 3'b111) code[4:2] = 3'b000;
      end
      run_instr($sformatf("rand %03b/%02b", code[4:2], code[1:0]),
                code[4:2], code[1:0], -1);
    end

    // Last instruction must have handed back to a normal fetch.
    check("final IF1", W0);
    @(posedge clk); #1;
    check("final IF2", LOADIR);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
